// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared scheduler types and width helpers for the voice synth
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    function automatic int voice_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Full-precision mix width: one extra bit per doubling of the voice count.
    function automatic int sample_width(input int data_w, input int n);
        return data_w + voice_idx_w(n);
    endfunction

endpackage

// File: rtl/voice_phase_bank.sv
// rtl/voice_phase_bank.sv - per-voice tuning words and phase accumulators
module voice_phase_bank
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [voice_idx_w(NUM_VOICES)-1:0]   wr_voice,
    input  logic [PHASE_WIDTH-1:0]               wr_data,
    input  logic [voice_idx_w(NUM_VOICES)-1:0]   sel,
    input  logic                                 adv,
    input  logic                                 clr,
    output logic [ADDR_WIDTH-1:0]                rd_addr
);

    logic [PHASE_WIDTH-1:0] ftw   [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] phase [NUM_VOICES];

    // A write landing on the selected voice's advance edge still advances by the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                ftw[v]   <= '0;
                phase[v] <= '0;
            end
        end else begin
            if (wr_en) begin
                ftw[wr_voice] <= wr_data;
            end
            if (adv) begin
                phase[sel] <= clr ? '0 : phase[sel] + ftw[sel];
            end
        end
    end

    assign rd_addr = phase[sel][PHASE_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/sin_voice_sched.sv
// rtl/sin_voice_sched.sv - shares one sine ROM across DDS voices and mixes them per tick
module sin_voice_sched
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              tick,
    input  logic                                              wr_en,
    input  logic [voice_idx_w(NUM_VOICES)-1:0]                wr_voice,
    input  logic [PHASE_WIDTH-1:0]                            wr_data,
    input  logic [NUM_VOICES-1:0]                             voice_en,
    output logic [ADDR_WIDTH-1:0]                             rom_addr,
    input  logic [DATA_WIDTH-1:0]                             rom_dout,
    output logic [sample_width(DATA_WIDTH, NUM_VOICES)-1:0]   sample,
    output logic                                              sample_valid,
    output logic                                              busy,
    output logic                                              overrun,
    input  logic                                              clr_overrun
);

    localparam int IDX_W = voice_idx_w(NUM_VOICES);
    localparam int SW    = sample_width(DATA_WIDTH, NUM_VOICES);

    sched_state_t          state, state_nx;
    logic [IDX_W-1:0]      idx;
    logic                  d_valid;
    logic                  d_en;
    logic signed [SW-1:0]  acc;
    logic signed [SW-1:0]  acc_nx;
    logic signed [SW-1:0]  term;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  issue;

    assign issue = (state == ISSUE);
    assign busy  = (state != IDLE);

    voice_phase_bank #(
        .NUM_VOICES  (NUM_VOICES),
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_voice (wr_voice),
        .wr_data  (wr_data),
        .sel      (idx),
        .adv      (issue),
        .clr      (!voice_en[idx]),
        .rd_addr  (cur_addr)
    );

    // Outside ISSUE the address just parks on the last value issued.
    assign rom_addr = issue ? cur_addr : addr_hold;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = ISSUE;
            ISSUE:   if (idx == IDX_W'(NUM_VOICES - 1)) state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // rom_dout belongs to the voice issued one cycle earlier, tracked by d_valid/d_en.
    always_comb begin
        term   = '0;
        if (d_valid && d_en) begin
            term = {{(SW - DATA_WIDTH){rom_dout[DATA_WIDTH-1]}}, rom_dout};
        end
        acc_nx = acc + term;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            d_valid      <= 1'b0;
            d_en         <= 1'b0;
            acc          <= '0;
            addr_hold    <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nx;
            sample_valid <= 1'b0;
            d_valid      <= issue;
            d_en         <= issue && voice_en[idx];
            case (state)
                IDLE: begin
                    if (tick) begin
                        idx <= '0;
                        acc <= '0;
                    end
                end
                ISSUE: begin
                    idx       <= idx + IDX_W'(1);
                    acc       <= acc_nx;
                    addr_hold <= cur_addr;
                end
                DRAIN: begin
                    acc          <= acc_nx;
                    sample       <= acc_nx;
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
            if (tick && busy) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sin_voice_sched.sv
// tb/tb_sin_voice_sched.sv - scoreboard bench for sin_voice_sched with a ram[i]=i sine ROM
module tb_sin_voice_sched;

    logic        clk = 1'b0;
    logic        reset, tick, wr_en, clr_overrun;
    logic [1:0]  wr_voice;
    logic [31:0] wr_data;
    logic [3:0]  voice_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout = 16'h0000;
    logic [17:0] sample;
    logic        sample_valid, busy, overrun;

    int tests = 0;
    int fails = 0;
    int sv_count = 0;

    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic [17:0] e, o;
    logic [7:0]  addr_log [8];
    logic [7:0]  busy_log, sv_log;
    logic [31:0] m_phase [4];
    logic [31:0] m_ftw [4];
    logic [15:0] ram [256];

    sin_voice_sched #(
        .NUM_VOICES (4), .PHASE_WIDTH (32), .ADDR_WIDTH (8), .DATA_WIDTH (16)
    ) dut (
        .clk (clk), .reset (reset), .tick (tick), .wr_en (wr_en),
        .wr_voice (wr_voice), .wr_data (wr_data), .voice_en (voice_en),
        .rom_addr (rom_addr), .rom_dout (rom_dout), .sample (sample),
        .sample_valid (sample_valid), .busy (busy), .overrun (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= ram[rom_addr];

    always @(negedge clk) begin
        if (sample_valid) begin
            obs_q.push_back(sample);
            sv_count++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; tick = 1'b0; wr_en = 1'b0; clr_overrun = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int v = 0; v < 4; v++) begin
            m_phase[v] = '0;
            m_ftw[v]   = '0;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic write_ftw(input int v, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_voice = v[1:0]; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        m_ftw[v] = d;
    endtask

    // Drives one tick, pushes the modelled mix, logs 8 cycles starting the cycle after the tick edge.
    task automatic send_tick();
        logic [17:0] s;
        s = '0;
        for (int v = 0; v < 4; v++) begin
            if (voice_en[v]) begin
                s = s + 18'(ram[m_phase[v][31:24]]);
                m_phase[v] = m_phase[v] + m_ftw[v];
            end else begin
                m_phase[v] = '0;
            end
        end
        @(negedge clk);
        tick = 1'b1;
        exp_q.push_back(s);
        @(negedge clk);
        tick = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            addr_log[k] = rom_addr;
            busy_log[k] = busy;
            sv_log[k]   = sample_valid;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (sample !== 18'd0) begin fails++; $display("FAIL reset_sample got=%0d want=0", sample); end
        tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_sample_valid got=%b want=0", sample_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        tests++; if (rom_addr !== 8'd0) begin fails++; $display("FAIL reset_rom_addr got=%0d want=0", rom_addr); end
    endtask

    task automatic test_latency();
        do_reset();
        voice_en = 4'b1111;
        send_tick();
        tests++; if (busy_log !== 8'b0001_1111) begin fails++; $display("FAIL lat_busy got=%b want=00011111", busy_log); end
        tests++; if (sv_log !== 8'b0010_0000) begin fails++; $display("FAIL lat_valid got=%b want=00100000", sv_log); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                fails++; $display("FAIL lat_sb_count exp_left=%0d obs_left=%0d", exp_q.size(), obs_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL lat_sample got=%0d want=%0d", o, e); end
            end
        end
    endtask

    task automatic test_single_voice();
        do_reset();
        voice_en = 4'b0001;
        write_ftw(0, 32'h0100_0000);
        for (int k = 0; k < 3; k++) begin
            send_tick();
            tests++;
            if (addr_log[0] !== 8'(k)) begin fails++; $display("FAIL single_addr tick=%0d got=%0d want=%0d", k, addr_log[0], k); end
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                fails++; $display("FAIL single_sb_count exp_left=%0d obs_left=%0d", exp_q.size(), obs_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL single_sample got=%0d want=%0d", o, e); end
            end
        end
    endtask

    task automatic test_mix();
        do_reset();
        voice_en = 4'b1111;
        for (int v = 0; v < 4; v++) write_ftw(v, 32'(v + 1) << 24);
        for (int k = 0; k < 3; k++) send_tick();
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                fails++; $display("FAIL mix_sb_count exp_left=%0d obs_left=%0d", exp_q.size(), obs_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL mix_sample got=%0d want=%0d", o, e); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ea;
        do_reset();
        voice_en = 4'b1000;
        write_ftw(3, 32'hFF00_0000);
        for (int k = 0; k < 257; k++) begin
            send_tick();
            ea = 8'(256 - k);
            tests++;
            if (addr_log[3] !== ea) begin fails++; $display("FAIL wrap_addr tick=%0d got=%0d want=%0d", k, addr_log[3], ea); end
        end
        voice_en = 4'b0000;
        send_tick();
        voice_en = 4'b1000;
        send_tick();
        tests++; if (addr_log[3] !== 8'd0) begin fails++; $display("FAIL reenable_addr got=%0d want=0", addr_log[3]); end
        send_tick();
        tests++; if (addr_log[3] !== 8'd255) begin fails++; $display("FAIL reenable_next got=%0d want=255", addr_log[3]); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                fails++; $display("FAIL wrap_sb_count exp_left=%0d obs_left=%0d", exp_q.size(), obs_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL wrap_sample got=%0d want=%0d", o, e); end
            end
        end
    endtask

    task automatic test_overrun();
        int base;
        do_reset();
        voice_en = 4'b0001;
        write_ftw(0, 32'h0100_0000);
        base = sv_count;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            tick = 1'b1;
            exp_q.push_back(18'(m_phase[0][31:24]));
            m_phase[0] = m_phase[0] + m_ftw[0];
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
            tick = 1'b1;
            clr_overrun = (r == 1);
            @(negedge clk);
            tick = 1'b0;
            clr_overrun = 1'b0;
            tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set round=%0d got=%b want=1", r, overrun); end
            repeat (8) @(negedge clk);
            tests++;
            if (sv_count - base !== r + 1) begin fails++; $display("FAIL overrun_valid_count round=%0d got=%0d want=%0d", r, sv_count - base, r + 1); end
            if (r == 0) begin
                clr_overrun = 1'b1;
                @(negedge clk);
                clr_overrun = 1'b0;
                tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear got=%b want=0", overrun); end
            end
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                fails++; $display("FAIL ovr_sb_count exp_left=%0d obs_left=%0d", exp_q.size(), obs_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL ovr_sample got=%0d want=%0d", o, e); end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int base;
        do_reset();
        voice_en = 4'b1111;
        for (int v = 0; v < 4; v++) write_ftw(v, 32'(v + 1) << 24);
        send_tick();
        send_tick();
        base = sv_count;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got=%b want=0", busy); end
        for (int v = 0; v < 4; v++) begin
            m_phase[v] = '0;
            m_ftw[v]   = '0;
        end
        repeat (8) @(negedge clk);
        tests++; if (sv_count !== base) begin fails++; $display("FAIL midreset_valid got=%0d want=%0d", sv_count - base, 0); end
        for (int v = 0; v < 4; v++) write_ftw(v, 32'h0500_0000);
        send_tick();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (addr_log[k] !== 8'd0) begin fails++; $display("FAIL midreset_phase voice=%0d got=%0d want=0", k, addr_log[k]); end
        end
        send_tick();
        tests++; if (addr_log[2] !== 8'd5) begin fails++; $display("FAIL midreset_advance got=%0d want=5", addr_log[2]); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            tests++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                fails++; $display("FAIL midreset_sb_count exp_left=%0d obs_left=%0d", exp_q.size(), obs_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL midreset_sample got=%0d want=%0d", o, e); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        reset = 1'b1; tick = 1'b0; wr_en = 1'b0; clr_overrun = 1'b0;
        wr_voice = '0; wr_data = '0; voice_en = '0;
        busy_log = '0; sv_log = '0;
        test_reset();
        test_latency();
        test_single_voice();
        test_mix();
        test_wrap();
        test_overrun();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached tests=%0d", tests);
        $fatal(1);
    end

endmodule
